// File: rtl/pixel_stream_buffer.sv
// rtl/pixel_stream_buffer.sv - credit-driven elastic palette stage between solver read port and video sink
//
// Purpose: issues fetch credits upstream, maps each 4-bit iteration value through a
// writable 16-entry RGB565 palette and buffers the result in a DEPTH-entry FIFO so
// sink backpressure never loses pixels. Output beats carry start/end-of-packet flags.
//
// Ports:
//   clock, reset_n          system clock, asynchronous active-low reset
//   fetch_en                credit to the pixel iterator (one pixel may be issued)
//   in_valid/start/end/data pixel beat, LATENCY cycles after its fetch_en cycle
//   pal_we/addr/wdata       palette write port
//   out_ready               sink ready
//   out_valid/start/end/data FIFO head beat
//   overflow                sticky flag: a beat was dropped on a full FIFO
//   frame_count             completed output frames, wraps
module pixel_stream_buffer #(
  parameter int LATENCY = 2,
  parameter int DEPTH   = 8
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        fetch_en,
  input  logic        in_valid,
  input  logic        in_start,
  input  logic        in_end,
  input  logic [3:0]  in_data,
  input  logic        pal_we,
  input  logic [3:0]  pal_addr,
  input  logic [15:0] pal_wdata,
  input  logic        out_ready,
  output logic        out_valid,
  output logic        out_start,
  output logic        out_end,
  output logic [15:0] out_data,
  output logic        overflow,
  output logic [15:0] frame_count
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [15:0] PAL_INIT [16] = '{
    16'h0000, 16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0500, 16'h0600, 16'h0708,
    16'h0710, 16'h0618, 16'h0518, 16'h0418, 16'h0318, 16'h0218, 16'h0118, 16'h0018
  };

  typedef enum logic {SYNC = 1'b0, RUN = 1'b1} state_t;

  state_t             state;
  logic               arm;
  logic [LATENCY-1:0] issued;
  logic [AW:0]        occ;
  logic [AW:0]        inflight;
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [17:0]        mem [DEPTH];
  logic [15:0]        palette [16];
  logic [17:0]        head;
  logic               push_req;
  logic               pop;
  logic               push;

  // Credits still travelling through the iterator/solver pipeline.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < LATENCY; i++) begin
      inflight = inflight + (AW+1)'(issued[i]);
    end
  end

  // Never promise more beats than the FIFO can hold once the pipeline drains.
  assign fetch_en = arm & ((occ + inflight) < (AW+1)'(DEPTH));

  assign push_req = in_valid & ((state == RUN) | in_start);
  assign pop      = out_valid & out_ready;
  // A simultaneous pop frees a slot, so a full FIFO still accepts the beat.
  assign push     = push_req & ((occ < (AW+1)'(DEPTH)) | pop);

  assign head      = mem[rd_ptr];
  assign out_valid = (occ != '0);
  // Gating keeps outputs at zero while empty (including straight after reset).
  assign out_start = out_valid & head[17];
  assign out_end   = out_valid & head[16];
  assign out_data  = out_valid ? head[15:0] : 16'h0000;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= SYNC;
      arm         <= 1'b0;
      issued      <= '0;
      occ         <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      overflow    <= 1'b0;
      frame_count <= 16'h0000;
      for (int i = 0; i < 16; i++) begin
        palette[i] <= PAL_INIT[i];
      end
    end else begin
      arm    <= 1'b1;
      issued <= (issued << 1) | LATENCY'(fetch_en);

      if ((state == SYNC) && in_valid && in_start) begin
        state <= RUN;
      end

      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   occ <= occ + (AW+1)'(1);
        2'b01:   occ <= occ - (AW+1)'(1);
        default: occ <= occ;
      endcase

      if (push_req && !push) begin
        overflow <= 1'b1;
      end
      if (pop && out_end) begin
        frame_count <= frame_count + 16'd1;
      end

      // The push above already read the old entry combinationally this cycle.
      if (pal_we) begin
        palette[pal_addr] <= pal_wdata;
      end
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= {in_start, in_end, palette[in_data]};
    end
  end

endmodule

// File: tb/tb_pixel_stream_buffer.sv
// tb/tb_pixel_stream_buffer.sv - self-checking bench for pixel_stream_buffer
module tb_pixel_stream_buffer;

  localparam int LAT = 2;
  localparam int DEP = 8;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        fetch_en;
  logic        in_valid = 1'b0;
  logic        in_start = 1'b0;
  logic        in_end = 1'b0;
  logic [3:0]  in_data = 4'h0;
  logic        pal_we = 1'b0;
  logic [3:0]  pal_addr = 4'h0;
  logic [15:0] pal_wdata = 16'h0000;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic        out_start;
  logic        out_end;
  logic [15:0] out_data;
  logic        overflow;
  logic [15:0] frame_count;

  always #5 clock = ~clock;

  pixel_stream_buffer #(.LATENCY(LAT), .DEPTH(DEP)) dut (
    .clock(clock), .reset_n(reset_n), .fetch_en(fetch_en),
    .in_valid(in_valid), .in_start(in_start), .in_end(in_end), .in_data(in_data),
    .pal_we(pal_we), .pal_addr(pal_addr), .pal_wdata(pal_wdata),
    .out_ready(out_ready), .out_valid(out_valid), .out_start(out_start),
    .out_end(out_end), .out_data(out_data), .overflow(overflow), .frame_count(frame_count)
  );

  logic [15:0] def_pal [16] = '{
    16'h0000, 16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0500, 16'h0600, 16'h0708,
    16'h0710, 16'h0618, 16'h0518, 16'h0418, 16'h0318, 16'h0218, 16'h0118, 16'h0018
  };

  // Reference model: FIFO as a queue of {start,end,rgb}, palette as an array.
  logic [17:0] mq [$];
  logic [15:0] mpal [16];
  bit          mrun, marmed, movf;
  logic [15:0] mfc;
  bit          fe1, fe2;          // model fetch_en one and two cycles ago
  logic [17:0] emitted [$];
  logic [17:0] saved [$];

  int checks = 0;
  int errors = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic bit model_fetch();
    return marmed && ((mq.size() + int'(fe1) + int'(fe2)) < DEP);
  endfunction

  task automatic model_reset();
    mq.delete();
    for (int i = 0; i < 16; i++) mpal[i] = def_pal[i];
    mrun = 0; marmed = 0; movf = 0; mfc = 16'h0000; fe1 = 0; fe2 = 0;
  endtask

  task automatic model_step();
    bit          fe;
    bit          popped;
    bit          preq;
    int          sz;
    logic [17:0] w;
    fe     = model_fetch();
    sz     = mq.size();
    popped = (sz != 0) && out_ready;
    preq   = in_valid && (mrun || in_start);
    if (popped) begin
      w = mq.pop_front();
      if (w[16]) mfc = mfc + 16'd1;
    end
    if (preq) begin
      if (sz < DEP || popped) mq.push_back({in_start, in_end, mpal[in_data]});
      else movf = 1;
    end
    if (in_valid && in_start) mrun = 1;
    if (pal_we) mpal[pal_addr] = pal_wdata;
    fe2 = fe1; fe1 = fe; marmed = 1;
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic cycle();
    @(negedge clock);
    chk("out_valid", out_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      chk("out_data", out_data, mq[0][15:0]);
      chk("out_start", out_start, mq[0][17]);
      chk("out_end", out_end, mq[0][16]);
    end
    chk("fetch_en", fetch_en, model_fetch());
    chk("overflow", overflow, movf);
    chk("frame_count", frame_count, mfc);
    if (out_valid && out_ready) emitted.push_back({out_start, out_end, out_data});
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic beat(bit v, bit s, bit e, logic [3:0] d);
    in_valid = v; in_start = s; in_end = e; in_data = d;
    cycle();
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) beat(0, 0, 0, 4'h0);
  endtask

  task automatic iter_cycle();
    in_valid = fe2; in_start = 0; in_end = 0; in_data = 4'($urandom_range(0, 14));
    cycle();
  endtask

  task automatic do_reset();
    in_valid = 0; in_start = 0; in_end = 0; in_data = 0; pal_we = 0;
    reset_n = 0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_fetch_en", fetch_en, 0);
    chk("rst_out_data", out_data, 16'h0000);
    chk("rst_out_flags", {out_start, out_end}, 2'b00);
    chk("rst_overflow", overflow, 0);
    chk("rst_frame_count", frame_count, 16'h0000);
    model_reset();
    @(posedge clock);
    #1;
    reset_n = 1;
    emitted.delete();
  endtask

  initial begin
    model_reset();
    do_reset();

    // fetch_en comes up one cycle after release
    chk("fetch_en_release", fetch_en, 0);
    out_ready = 1;
    idle(1);
    chk("fetch_en_armed", fetch_en, 1);

    // eight beats, indices 0..7
    emitted.delete();
    for (int i = 0; i < 8; i++) beat(1, i == 0, 0, 4'(i));
    idle(2);
    chk("seq_count", emitted.size(), 8);
    for (int i = 0; i < 8 && i < emitted.size(); i++)
      chk("seq_word", emitted[i], {i == 0, 1'b0, def_pal[i]});

    // beats before a start are discarded
    do_reset();
    out_ready = 1;
    beat(1, 0, 0, 4'd3);
    beat(1, 0, 0, 4'd3);
    beat(1, 1, 0, 4'd5);
    idle(2);
    chk("sync_count", emitted.size(), 1);
    if (emitted.size() > 0) chk("sync_word", emitted[0], {2'b10, 16'h0500});

    // backpressure fills to DEPTH with credits honoured
    out_ready = 0;
    for (int i = 0; i < 20; i++) iter_cycle();
    chk("model_full", mq.size(), 8);
    chk("fetch_en_full", fetch_en, 0);
    saved = mq;
    emitted.delete();
    out_ready = 1;
    idle(10);
    chk("drain_count", emitted.size(), 8);
    for (int i = 0; i < 8 && i < emitted.size(); i++) chk("drain_word", emitted[i], saved[i]);
    chk("drain_no_overflow", overflow, 0);

    // extra beat into a full FIFO is dropped
    out_ready = 0;
    for (int i = 0; i < 20; i++) iter_cycle();
    beat(1, 0, 1, 4'd15);
    idle(2);
    chk("overflow_set", overflow, 1);
    emitted.delete();
    out_ready = 1;
    idle(10);
    chk("ovf_drain_count", emitted.size(), 8);
    for (int i = 0; i < emitted.size(); i++) chk("ovf_absent", emitted[i][15:0] == 16'h0018, 0);
    chk("overflow_sticky", overflow, 1);

    // palette write coinciding with a push of the same index
    do_reset();
    out_ready = 1;
    pal_we = 1; pal_addr = 4'd2; pal_wdata = 16'h1234;
    beat(1, 1, 0, 4'd2);
    pal_we = 0;
    beat(1, 0, 0, 4'd2);
    idle(2);
    chk("pal_count", emitted.size(), 2);
    if (emitted.size() > 1) begin
      chk("pal_old", emitted[0][15:0], 16'h0200);
      chk("pal_new", emitted[1][15:0], 16'h1234);
    end

    // randomized traffic with credits honoured
    for (int i = 0; i < 3000; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = fe2;
      in_start  = ($urandom_range(0, 15) == 0);
      in_end    = ($urandom_range(0, 15) == 0);
      in_data   = 4'($urandom);
      pal_we    = ($urandom_range(0, 7) == 0);
      pal_addr  = 4'($urandom);
      pal_wdata = 16'($urandom);
      cycle();
    end
    pal_we = 0;

    // frame counter wrap
    do_reset();
    out_ready = 1;
    for (int n = 0; n < 65535; n++) beat(1, n == 0, 1, 4'(n));
    idle(2);
    chk("fc_ffff", frame_count, 16'hffff);
    beat(1, 0, 1, 4'd1);
    idle(2);
    chk("fc_wrap", frame_count, 16'h0000);

    // reset mid-frame clears output at once, then waits for a start
    out_ready = 0;
    beat(1, 0, 0, 4'd1);
    beat(1, 0, 0, 4'd2);
    beat(1, 0, 0, 4'd3);
    chk("midframe_valid", out_valid, 1);
    do_reset();
    out_ready = 1;
    beat(1, 0, 0, 4'd4);
    idle(2);
    chk("resume_none", emitted.size(), 0);
    beat(1, 1, 0, 4'd6);
    idle(2);
    chk("resume_count", emitted.size(), 1);
    if (emitted.size() > 0) chk("resume_word", emitted[0], {2'b10, 16'h0600});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pixel_stream_buffer.md
# pixel_stream_buffer

Elastic colour-mapping stage between the multi-solver read port and the video streaming sink. It issues fetch credits to the pixel iterator and absorbs the solver's fixed read latency in a small FIFO, so sink backpressure never drops pixels. Each 4-bit iteration value passes through a writable 16-entry RGB565 palette. The block emits an Avalon-ST video packet with start/end-of-packet aligned to frame boundaries.

## Interface
- LATENCY, 2: cycles from a `fetch_en` cycle to the matching `in_valid` beat (iterator plus solver read pipeline).
- DEPTH, 8: FIFO entries; power of two, must be at least LATENCY+2.
- clock  in  1  system clock (CLOCK_50 domain).
- reset_n  in  1  asynchronous, active-low reset.
- fetch_en  out  1  upstream may advance and issue one pixel this cycle (drives pixel_iterator `en`).
- in_valid  in  1  pixel beat present, LATENCY cycles after its `fetch_en` cycle.
- in_start  in  1  beat is the first pixel of a frame.
- in_end  in  1  beat is the last pixel of a frame.
- in_data  in  4  iteration value (palette index).
- pal_we  in  1  palette write strobe.
- pal_addr  in  4  palette entry to write.
- pal_wdata  in  16  RGB565 value to write.
- out_ready  in  1  sink ready.
- out_valid  out  1  FIFO head valid.
- out_start  out  1  head beat start-of-packet.
- out_end  out  1  head beat end-of-packet.
- out_data  out  16  head beat RGB565 value.
- overflow  out  1  sticky; set when an accepted-state beat is dropped because the FIFO is full.
- frame_count  out  16  count of completed output frames; wraps.

## Operation
- Credit: `inflight` = number of `fetch_en`-high cycles among the last LATENCY cycles, held in a LATENCY-bit shift register.
- `fetch_en = arm & (occ + inflight < DEPTH)`. `arm` is a flop cleared by reset and set on the first clock edge after reset release.
- Push: `in_valid` in RUN, or the sync beat. The beat is accepted if `occ < DEPTH`, or if a pop happens in the same cycle. Otherwise the beat is dropped and `overflow` is set.
- Stored word is `{in_start, in_end, palette[in_data]}`, 18 bits.
- Palette read is combinational at push. A palette write in the same cycle to the same index is not seen by that push (old value used); the new value is used from the next cycle.
- Palette reset values, indices 0..15: 0000, 0100, 0200, 0300, 0400, 0500, 0600, 0708, 0710, 0618, 0518, 0418, 0318, 0218, 0118, 0018 (hex).
- Pop: when `out_valid & out_ready`.
- `out_valid = (occ != 0)`. `out_*` show the FIFO head and hold stable while `out_valid & !out_ready`.
- Sync FSM has two states:
  - SYNC (reset state): discard `in_valid` beats until one has `in_start=1`. That beat is pushed and the FSM moves to RUN.
  - RUN: push every beat. Stays in RUN; only reset returns it to SYNC.
- `frame_count` increments on each pop with `out_end=1`; FFFF wraps to 0000.
- Occupancy uses an `log2(DEPTH)+1`-bit count. Read and write pointers wrap modulo DEPTH.

## Timing
- Reset values:
  - fetch_en=0, out_valid=0, out_start=0, out_end=0, out_data=0000.
  - overflow=0, frame_count=0, occ=0, inflight=0, FSM=SYNC, palette=defaults.
- Reset asserted mid-frame: FIFO contents are discarded immediately (asynchronously). After release, output resumes only at the next `in_start`.
- Latency from an accepted push to `out_valid` is 1 cycle when the FIFO was empty.
- `fetch_en` rises 1 cycle after reset release.
- Full throughput is 1 pixel per clock with `out_ready` held high. Under this rule `overflow` never sets when upstream honours LATENCY.
- Push and pop in the same cycle: occupancy is unchanged; the full condition is not considered.
- Pop on empty is impossible because `out_valid=0`.

## Test plan
- Reset then 8 beats with index 0..7, first beat `in_start=1`, `out_ready=1` -> out_data 0000,0100,…,0708 in order, `out_start` on the first beat only, each beat 1 cycle after its input.
- Beats before any `in_start` (indices 3,3), then a start beat with index 5 -> only 0500 is emitted, flagged `out_start`.
- `out_ready=0` for 20 cycles with the iterator model honouring `fetch_en` and LATENCY=2 -> occ reaches 8 and `fetch_en` drops. Then `out_ready=1` drains all 8 beats in order, with no loss and `overflow=0`.
- Inject an extra `in_valid` beat while occ=8 and no pop -> the beat is absent from the output and `overflow` reads 1 until reset.
- `pal_we` to index 2 with 1234 in the same cycle as an index-2 push -> that push emits 0200, and the next index-2 push emits 1234.
- Preload frame_count to FFFF via 65535 `in_end` beats, then one more frame end -> frame_count = 0000. Also assert reset_n low mid-frame -> out_valid=0 immediately.
